// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if: requester ports and RAM-side bus of the CHIP-8 RAM arbiter
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              cpu_read;
  logic [ADDR_W-1:0] cpu_read_addr;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cpu_read_ack;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_write_addr;
  logic [DATA_W-1:0] cpu_write_data;
  logic              cpu_write_ack;
  logic              vid_read;
  logic [ADDR_W-1:0] vid_read_addr;
  logic [DATA_W-1:0] vid_read_data;
  logic              vid_read_ack;
  logic              ld_write;
  logic [ADDR_W-1:0] ld_write_addr;
  logic [DATA_W-1:0] ld_write_data;
  logic              ld_write_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        grant;
  modport slave (
    input  cpu_read, cpu_read_addr, cpu_write, cpu_write_addr, cpu_write_data,
    input  vid_read, vid_read_addr, ld_write, ld_write_addr, ld_write_data, ram_rdata,
    output cpu_read_data, cpu_read_ack, cpu_write_ack, vid_read_data, vid_read_ack,
    output ld_write_ack, ram_en, ram_we, ram_addr, ram_wdata, grant
  );
  modport master (
    output cpu_read, cpu_read_addr, cpu_write, cpu_write_addr, cpu_write_data,
    output vid_read, vid_read_addr, ld_write, ld_write_addr, ld_write_data, ram_rdata,
    input  cpu_read_data, cpu_read_ack, cpu_write_ack, vid_read_data, vid_read_ack,
    input  ld_write_ack, ram_en, ram_we, ram_addr, ram_wdata, grant
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: serialises loader/CPU/display accesses to the single-port CHIP-8 RAM
// (define CHIP8_MEM_ARB_RR_EN for CPU/display round-robin; default is fixed CPU > display)
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst_n,
  chip8_mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]        state;
  logic              wr_q;
  logic              cpu_req;
  logic              pick_vid;
  logic [1:0]        nxt_grant;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata;
`ifdef CHIP8_MEM_ARB_RR_EN
  logic              ptr;
`endif
  // pick the winner among the live requests: loader first, then CPU/display
  always_comb begin
    cpu_req   = bus.cpu_read | bus.cpu_write;
`ifdef CHIP8_MEM_ARB_RR_EN
    pick_vid  = bus.vid_read & (~cpu_req | ptr);
`else
    pick_vid  = bus.vid_read & ~cpu_req;
`endif
    nxt_grant = bus.ld_write ? 2'd1 : pick_vid ? 2'd3 : cpu_req ? 2'd2 : 2'd0;
    nxt_we    = bus.ld_write | (~pick_vid & bus.cpu_write);
    nxt_addr  = bus.ld_write ? bus.ld_write_addr :
                pick_vid ? bus.vid_read_addr :
                bus.cpu_write ? bus.cpu_write_addr : bus.cpu_read_addr;
    nxt_wdata = bus.ld_write ? bus.ld_write_data : bus.cpu_write_data;
  end
  // four-phase access sequencer: grant/issue, RAM sample, capture+ack, release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wr_q              <= 1'b0;
      bus.grant         <= 2'd0;
      bus.ram_en        <= 1'b0;
      bus.ram_we        <= 1'b0;
      bus.ram_addr      <= '0;
      bus.ram_wdata     <= '0;
      bus.cpu_read_data <= '0;
      bus.vid_read_data <= '0;
      bus.cpu_read_ack  <= 1'b0;
      bus.cpu_write_ack <= 1'b0;
      bus.vid_read_ack  <= 1'b0;
      bus.ld_write_ack  <= 1'b0;
`ifdef CHIP8_MEM_ARB_RR_EN
      ptr               <= 1'b0;
`endif
    end else begin
      bus.cpu_read_ack  <= 1'b0;
      bus.cpu_write_ack <= 1'b0;
      bus.vid_read_ack  <= 1'b0;
      bus.ld_write_ack  <= 1'b0;
      case (state)
        IDLE: if (nxt_grant != 2'd0) begin
          state        <= ISSUE;
          bus.grant    <= nxt_grant;
          wr_q         <= nxt_we;
          bus.ram_en   <= 1'b1;
          bus.ram_we   <= nxt_we;
          bus.ram_addr <= nxt_addr;
          if (nxt_we) bus.ram_wdata <= nxt_wdata;
`ifdef CHIP8_MEM_ARB_RR_EN
          if (nxt_grant == 2'd2) ptr <= 1'b1;
          if (nxt_grant == 2'd3) ptr <= 1'b0;
`endif
        end
        ISSUE: begin
          bus.ram_en <= 1'b0;
          bus.ram_we <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          bus.ld_write_ack  <= bus.grant == 2'd1;
          bus.cpu_write_ack <= bus.grant == 2'd2 && wr_q;
          bus.cpu_read_ack  <= bus.grant == 2'd2 && !wr_q;
          bus.vid_read_ack  <= bus.grant == 2'd3;
          if (bus.grant == 2'd2 && !wr_q) bus.cpu_read_data <= bus.ram_rdata;
          if (bus.grant == 2'd3) bus.vid_read_data <= bus.ram_rdata;
          state <= DONE;
        end
        default: begin
          bus.grant <= 2'd0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: directed and random traffic against a transaction-level arbiter model
module tb_chip8_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_init = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  chip8_mem_arbiter_if bus ();
  chip8_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] mem [4096];
  // RAM macro: synchronous, one-cycle read latency
  always @(posedge clk)
    if (ram_init) for (int i = 0; i < 4096; i++) mem[i] <= 8'(i * 7 + 3);
    else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  logic [7:0]  shadow [4096];
  int          phase;
  logic [1:0]  who;
  logic        wr, rr_vid;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata, m_rd, exp_cpu_rd, exp_vid_rd;
  int          ack_cnt [4];
  logic [1:0]  glog [$];
  logic [7:0]  rlog [$];
  int          tlog [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_edge();
    logic c, v, pv;
    if (!rst_n) begin
      phase = 0; who = 0; wr = 0; m_addr = 0; m_wdata = 0;
      exp_cpu_rd = 0; exp_vid_rd = 0; rr_vid = 0;
    end else if (phase == 0) begin
      c = bus.cpu_read | bus.cpu_write;
      v = bus.vid_read;
`ifdef CHIP8_MEM_ARB_RR_EN
      pv = v & (~c | rr_vid);
`else
      pv = v & ~c;
`endif
      if (bus.ld_write) begin
        who = 1; wr = 1; m_addr = bus.ld_write_addr; m_wdata = bus.ld_write_data;
      end else if (pv) begin
        who = 3; wr = 0; m_addr = bus.vid_read_addr; rr_vid = 0;
      end else if (c) begin
        who = 2; wr = bus.cpu_write; rr_vid = 1;
        m_addr = wr ? bus.cpu_write_addr : bus.cpu_read_addr;
        if (wr) m_wdata = bus.cpu_write_data;
      end
      if (bus.ld_write | c | v) begin
        phase = 1;
        if (wr) shadow[m_addr] = m_wdata;
        else m_rd = shadow[m_addr];
      end
    end else begin
      phase = phase == 3 ? 0 : phase + 1;
      if (phase == 3 && !wr) begin
        if (who == 2) exp_cpu_rd = m_rd;
        if (who == 3) exp_vid_rd = m_rd;
      end
    end
  endtask
  task automatic compare();
    logic [3:0] ea;
    ea = phase == 3 ? {who == 1, who == 2 && wr, who == 2 && !wr, who == 3} : 4'd0;
    check("grant", 32'(bus.grant), phase != 0 ? 32'(who) : 32'd0);
    check("ram_en", 32'(bus.ram_en), 32'(phase == 1));
    check("ram_we", 32'(bus.ram_we), 32'(phase == 1 && wr));
    check("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
    if (phase == 1 && wr) check("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
    check("acks", 32'({bus.ld_write_ack, bus.cpu_write_ack, bus.cpu_read_ack, bus.vid_read_ack}), 32'(ea));
    check("cpu_rd", 32'(bus.cpu_read_data), 32'(exp_cpu_rd));
    check("vid_rd", 32'(bus.vid_read_data), 32'(exp_vid_rd));
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
  endtask
  task automatic clear_logs();
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    glog.delete(); rlog.delete(); tlog.delete();
  endtask
  task automatic run(input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.ram_en) glog.push_back(bus.grant);
      if (bus.ld_write_ack) begin ack_cnt[0]++; if (drop) bus.ld_write = 0; end
      if (bus.cpu_write_ack) begin ack_cnt[1]++; if (drop) bus.cpu_write = 0; end
      if (bus.cpu_read_ack) begin
        ack_cnt[2]++; rlog.push_back(bus.cpu_read_data); tlog.push_back(cyc);
        if (drop) bus.cpu_read = 0; else bus.cpu_read_addr = bus.cpu_read_addr + 12'd1;
      end
      if (bus.vid_read_ack) begin ack_cnt[3]++; if (drop) bus.vid_read = 0; end
    end
  endtask
  task automatic reset_dut();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask
  initial begin
    int c0;
    bus.cpu_read = 0; bus.cpu_read_addr = 0; bus.cpu_write = 0; bus.cpu_write_addr = 0;
    bus.cpu_write_data = 0; bus.vid_read = 0; bus.vid_read_addr = 0;
    bus.ld_write = 0; bus.ld_write_addr = 0; bus.ld_write_data = 0;
    for (int i = 0; i < 4096; i++) shadow[i] = 8'(i * 7 + 3);
    ram_init = 1;
    reset_dut();
    ram_init = 0;
    // loader write then CPU read of the same byte
    clear_logs();
    bus.ld_write = 1; bus.ld_write_addr = 12'h200; bus.ld_write_data = 8'hA5;
    run(4, 1);
    bus.cpu_read = 1; bus.cpu_read_addr = 12'h200;
    c0 = cyc;
    run(4, 1);
    check("ld_acks", 32'(ack_cnt[0]), 32'd1);
    check("t1_rd", 32'(rlog[0]), 32'hA5);
    check("rd_lat", 32'(tlog[0] - c0), 32'd3);
    // all three request together, each drops on its ack
    reset_dut();
    clear_logs();
    bus.ld_write = 1; bus.ld_write_addr = 12'h400; bus.ld_write_data = 8'h11;
    bus.cpu_read = 1; bus.cpu_read_addr = 12'h400; bus.vid_read = 1; bus.vid_read_addr = 12'h401;
    run(12, 1);
    check("seq_len", 32'(glog.size()), 32'd3);
    check("seq0", 32'(glog[0]), 32'd1);
    check("seq1", 32'(glog[1]), 32'd2);
    check("seq2", 32'(glog[2]), 32'd3);
    // CPU and display both hold requests continuously
    reset_dut();
    clear_logs();
    bus.cpu_read = 1; bus.cpu_read_addr = 12'h500; bus.vid_read = 1; bus.vid_read_addr = 12'h600;
    run(12, 0);
    bus.cpu_read = 0; bus.vid_read = 0;
    check("cont0", 32'(glog[0]), 32'd2);
`ifdef CHIP8_MEM_ARB_RR_EN
    check("cont1", 32'(glog[1]), 32'd3);
`else
    check("cont1", 32'(glog[1]), 32'd2);
`endif
    check("cont2", 32'(glog[2]), 32'd2);
    // simultaneous CPU read and write: write first
    clear_logs();
    bus.cpu_write = 1; bus.cpu_write_addr = 12'h300; bus.cpu_write_data = 8'h3C;
    bus.cpu_read = 1; bus.cpu_read_addr = 12'h300;
    run(8, 1);
    check("rw_order", 32'(glog[0]), 32'd2);
    check("rw_wack", 32'(ack_cnt[1]), 32'd1);
    check("rw_rd", 32'(rlog[0]), 32'h3C);
    // read request dropped after grant still completes once
    clear_logs();
    bus.cpu_read = 1; bus.cpu_read_addr = 12'h210;
    run(2, 1);
    bus.cpu_read = 0;
    run(6, 1);
    check("drop_ack", 32'(ack_cnt[2]), 32'd1);
    check("drop_grants", 32'(glog.size()), 32'd1);
    // reset during the ISSUE phase aborts the access
    clear_logs();
    bus.cpu_read = 1; bus.cpu_read_addr = 12'h205;
    run(1, 1);
    rst_n = 0;
    #1;
    check("rst_en", 32'(bus.ram_en), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_acks", 32'({bus.ld_write_ack, bus.cpu_write_ack, bus.cpu_read_ack, bus.vid_read_ack}), 32'd0);
    bus.cpu_read = 0;
    step();
    rst_n = 1;
    run(6, 1);
    check("rst_stale", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]), 32'd0);
    // back-to-back fetch with request held high
    clear_logs();
    bus.cpu_read = 1; bus.cpu_read_addr = 12'h200;
    run(8, 0);
    bus.cpu_read = 0;
    check("fetch0", 32'(rlog[0]), 32'hA5);
    check("fetch1", 32'(rlog[1]), 32'h0A);
    check("fetch_gap", 32'(tlog[1] - tlog[0]), 32'd4);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.ld_write = $urandom_range(0, 7) == 0;
      bus.ld_write_addr = 12'h200 + 12'($urandom_range(0, 15));
      bus.ld_write_data = 8'($urandom);
      bus.cpu_read = 1'($urandom_range(0, 1));
      bus.cpu_read_addr = 12'h200 + 12'($urandom_range(0, 15));
      bus.cpu_write = $urandom_range(0, 3) == 0;
      bus.cpu_write_addr = 12'h200 + 12'($urandom_range(0, 15));
      bus.cpu_write_data = 8'($urandom);
      bus.vid_read = 1'($urandom_range(0, 1));
      bus.vid_read_addr = 12'h200 + 12'($urandom_range(0, 15));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
